rr_arbiter_4: RTL and testbench

RR_ARBITER_4 -- requirements
Module: rr_arbiter_4

---
 rtl/rr_arbiter_4.sv | 138 +++++++++++++
 tb/tb_rr_arbiter_4.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/rr_arbiter_4.sv
// Four-way round-robin arbiter with an optional per-owner hold limit.
// Grants are registered; a one-cycle RELEASE gap separates consecutive owners.
module rr_arbiter_4 #(
    parameter int unsigned MAX_HOLD = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic [1:0] gnt_id,
    output logic       busy,
    output logic       timeout
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } state_t;

    localparam logic [3:0] HOLD_LIMIT = 4'(MAX_HOLD);
    localparam bit         HOLD_EN    = (MAX_HOLD != 0);

    state_t     state_reg, state_next;
    logic [1:0] last_reg, last_next;
    logic [3:0] cnt_reg, cnt_next;
    logic [3:0] gnt_reg, gnt_next;
    logic [1:0] gnt_id_reg, gnt_id_next;
    logic       busy_reg, busy_next;
    logic       timeout_reg, timeout_next;

    // Candidate gi is the requester gi+1 places after the last owner.
    logic [1:0] cand_idx [4];
    logic [3:0] cand_req;
    logic [1:0] pick_idx;
    logic       pick_valid;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_cand
            assign cand_idx[gi] = last_reg + 2'(gi + 1);
            assign cand_req[gi] = req[cand_idx[gi]];
        end
    endgenerate

    // Walk from the farthest candidate back so the nearest one wins.
    always_comb begin
        pick_valid = |cand_req;
        pick_idx   = last_reg;
        for (int i = 3; i >= 0; i--) begin
            if (cand_req[i]) begin
                pick_idx = cand_idx[i];
            end
        end
    end

    always_comb begin
        state_next   = state_reg;
        last_next    = last_reg;
        cnt_next     = cnt_reg;
        gnt_next     = gnt_reg;
        gnt_id_next  = gnt_id_reg;
        busy_next    = busy_reg;
        timeout_next = 1'b0;

        case (state_reg)
            IDLE, RELEASE: begin
                if (pick_valid) begin
                    state_next  = GRANT;
                    gnt_next    = 4'b0001 << pick_idx;
                    gnt_id_next = pick_idx;
                    last_next   = pick_idx;
                    busy_next   = 1'b1;
                    cnt_next    = 4'd1;
                end else begin
                    state_next = IDLE;
                    gnt_next   = 4'b0000;
                    busy_next  = 1'b0;
                    cnt_next   = 4'd0;
                end
            end

            GRANT: begin
                if (!req[gnt_id_reg]) begin
                    state_next = RELEASE;
                    gnt_next   = 4'b0000;
                    busy_next  = 1'b0;
                    cnt_next   = 4'd0;
                end else if (HOLD_EN && (cnt_reg == HOLD_LIMIT)) begin
                    state_next   = RELEASE;
                    gnt_next     = 4'b0000;
                    busy_next    = 1'b0;
                    cnt_next     = 4'd0;
                    timeout_next = 1'b1;
                end else if (cnt_reg != 4'hF) begin
                    cnt_next = cnt_reg + 4'd1;
                end
            end

            default: begin
                state_next = IDLE;
                gnt_next   = 4'b0000;
                busy_next  = 1'b0;
                cnt_next   = 4'd0;
            end
        endcase
    end

    // last resets to 3 so requester 0 is first in line after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            last_reg    <= 2'd3;
            cnt_reg     <= 4'd0;
            gnt_reg     <= 4'b0000;
            gnt_id_reg  <= 2'd0;
            busy_reg    <= 1'b0;
            timeout_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            last_reg    <= last_next;
            cnt_reg     <= cnt_next;
            gnt_reg     <= gnt_next;
            gnt_id_reg  <= gnt_id_next;
            busy_reg    <= busy_next;
            timeout_reg <= timeout_next;
        end
    end

    assign gnt     = gnt_reg;
    assign gnt_id  = gnt_id_reg;
    assign busy    = busy_reg;
    assign timeout = timeout_reg;

    a_gnt_onehot0 : assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gnt_reg));
    a_busy_match  : assert property (@(posedge clk) disable iff (!rst_n) busy_reg == (|gnt_reg));

endmodule

// File: tb/tb_rr_arbiter_4.sv
// Directed bench for rr_arbiter_4: four instances cover the default hold
// limit, a short limit, a sole-requester timeout and an unlimited hold.
module tb_rr_arbiter_4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req_15, req_2, req_3, req_0;
    logic [3:0] gnt_15, gnt_2, gnt_3, gnt_0;
    logic [1:0] id_15, id_2, id_3, id_0;
    logic       busy_15, busy_2, busy_3, busy_0;
    logic       to_15, to_2, to_3, to_0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rr_arbiter_4 #(.MAX_HOLD(15)) u_h15 (
        .clk(clk), .rst_n(rst_n), .req(req_15),
        .gnt(gnt_15), .gnt_id(id_15), .busy(busy_15), .timeout(to_15)
    );
    rr_arbiter_4 #(.MAX_HOLD(2)) u_h2 (
        .clk(clk), .rst_n(rst_n), .req(req_2),
        .gnt(gnt_2), .gnt_id(id_2), .busy(busy_2), .timeout(to_2)
    );
    rr_arbiter_4 #(.MAX_HOLD(3)) u_h3 (
        .clk(clk), .rst_n(rst_n), .req(req_3),
        .gnt(gnt_3), .gnt_id(id_3), .busy(busy_3), .timeout(to_3)
    );
    rr_arbiter_4 #(.MAX_HOLD(0)) u_h0 (
        .clk(clk), .rst_n(rst_n), .req(req_0),
        .gnt(gnt_0), .gnt_id(id_0), .busy(busy_0), .timeout(to_0)
    );

    task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n  = 1'b0;
        req_15 = 4'b0;
        req_2  = 4'b0;
        req_3  = 4'b0;
        req_0  = 4'b0;
        repeat (2) tick();
        rst_n = 1'b1;
    endtask

    // Expected per-edge results for req=1111 with MAX_HOLD=2.
    logic [3:0] rr_gnt [13] = '{4'b0001, 4'b0001, 4'b0000, 4'b0010, 4'b0010, 4'b0000,
                                4'b0100, 4'b0100, 4'b0000, 4'b1000, 4'b1000, 4'b0000, 4'b0001};
    logic [1:0] rr_id  [13] = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1,
                                2'd2, 2'd2, 2'd2, 2'd3, 2'd3, 2'd3, 2'd0};
    // Expected per-edge results for sole requester 1 with MAX_HOLD=3.
    logic [3:0] sole_gnt [9] = '{4'b0010, 4'b0010, 4'b0010, 4'b0000,
                                 4'b0010, 4'b0010, 4'b0010, 4'b0000, 4'b0010};

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        req_15 = 4'b0; req_2 = 4'b0; req_3 = 4'b0; req_0 = 4'b0;

        // Reset values while rst_n is low.
        #3;
        check_eq("rst_gnt", gnt_15, 8'h00);
        check_eq("rst_id", id_15, 8'h00);
        check_eq("rst_busy", busy_15, 8'h00);
        check_eq("rst_timeout", to_15, 8'h00);

        // Single request, then drop.
        do_reset();
        req_15 = 4'b0100;
        tick();
        $display("single edge1: gnt=%b id=%0d busy=%0b", gnt_15, id_15, busy_15);
        check_eq("single_gnt1", gnt_15, 8'h04);
        check_eq("single_id1", id_15, 8'h02);
        check_eq("single_busy1", busy_15, 8'h01);
        tick();
        $display("single edge2: gnt=%b", gnt_15);
        check_eq("single_gnt2", gnt_15, 8'h04);
        req_15 = 4'b0000;
        tick();
        $display("single edge3: gnt=%b id=%0d timeout=%0b", gnt_15, id_15, to_15);
        check_eq("single_rel_gnt", gnt_15, 8'h00);
        check_eq("single_rel_busy", busy_15, 8'h00);
        check_eq("single_rel_id", id_15, 8'h02);
        check_eq("single_rel_to", to_15, 8'h00);
        tick();
        $display("single edge4: gnt=%b id=%0d", gnt_15, id_15);
        check_eq("single_idle_gnt", gnt_15, 8'h00);
        check_eq("single_idle_id", id_15, 8'h02);

        // Request withdrawn before it is sampled is never granted.
        req_15 = 4'b0000;
        tick();
        $display("withdrawn: gnt=%b", gnt_15);
        check_eq("withdrawn_gnt", gnt_15, 8'h00);

        // Owner 0 drops while requester 3 rises in the same cycle.
        do_reset();
        req_15 = 4'b0001;
        tick();
        check_eq("handoff_gnt0", gnt_15, 8'h01);
        req_15 = 4'b1000;
        tick();
        $display("handoff release: gnt=%b", gnt_15);
        check_eq("handoff_rel", gnt_15, 8'h00);
        check_eq("handoff_rel_to", to_15, 8'h00);
        tick();
        $display("handoff grant: gnt=%b id=%0d", gnt_15, id_15);
        check_eq("handoff_gnt3", gnt_15, 8'h08);
        check_eq("handoff_id3", id_15, 8'h03);
        // Non-owner requests must not disturb the current grant.
        req_15 = 4'b1111;
        tick();
        check_eq("nonowner_gnt", gnt_15, 8'h08);

        // Round-robin rotation with MAX_HOLD=2.
        do_reset();
        req_2 = 4'b1111;
        for (int i = 0; i < 13; i++) begin
            tick();
            $display("rr edge%0d: gnt=%b id=%0d timeout=%0b", i + 1, gnt_2, id_2, to_2);
            check_eq($sformatf("rr_gnt%0d", i + 1), gnt_2, rr_gnt[i]);
            check_eq($sformatf("rr_id%0d", i + 1), id_2, rr_id[i]);
            check_eq($sformatf("rr_to%0d", i + 1), to_2, (rr_gnt[i] == 4'b0000) ? 8'h01 : 8'h00);
            check_eq($sformatf("rr_busy%0d", i + 1), busy_2, (rr_gnt[i] != 4'b0000) ? 8'h01 : 8'h00);
        end

        // Sole requester repeatedly timed out with MAX_HOLD=3.
        do_reset();
        req_3 = 4'b0010;
        for (int i = 0; i < 9; i++) begin
            tick();
            $display("sole edge%0d: gnt=%b timeout=%0b", i + 1, gnt_3, to_3);
            check_eq($sformatf("sole_gnt%0d", i + 1), gnt_3, sole_gnt[i]);
            check_eq($sformatf("sole_to%0d", i + 1), to_3, (sole_gnt[i] == 4'b0000) ? 8'h01 : 8'h00);
        end

        // MAX_HOLD=0 keeps the grant past the counter's saturation point.
        do_reset();
        req_0 = 4'b0100;
        for (int i = 0; i < 20; i++) begin
            tick();
            $display("hold0 edge%0d: gnt=%b timeout=%0b", i + 1, gnt_0, to_0);
            check_eq($sformatf("hold0_gnt%0d", i + 1), gnt_0, 8'h04);
            check_eq($sformatf("hold0_to%0d", i + 1), to_0, 8'h00);
        end

        // Asynchronous reset in the middle of a grant.
        do_reset();
        req_15 = 4'b0010;
        tick();
        tick();
        check_eq("areset_pre_gnt", gnt_15, 8'h02);
        #3;
        rst_n = 1'b0;
        #1;
        $display("async reset: gnt=%b busy=%0b", gnt_15, busy_15);
        check_eq("areset_gnt", gnt_15, 8'h00);
        check_eq("areset_busy", busy_15, 8'h00);
        check_eq("areset_id", id_15, 8'h00);
        req_15 = 4'b1111;
        #1;
        rst_n = 1'b1;
        tick();
        $display("after reset: gnt=%b id=%0d", gnt_15, id_15);
        check_eq("areset_regnt", gnt_15, 8'h01);
        check_eq("areset_reid", id_15, 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Running one-hot guard on every instance at each negative edge.
    always @(negedge clk) begin
        if (rst_n) begin
            check_eq("onehot_h15", 8'($countones(gnt_15) <= 1), 8'h01);
            check_eq("onehot_h2", 8'($countones(gnt_2) <= 1), 8'h01);
        end
    end

endmodule
